// File: rtl/nco_pkg.sv
// nco_pkg: shared defaults and state encoding for the triangle NCO.
//   PHASE_W_DEF / ADDR_W_DEF / DATA_W_DEF / FRAC_W_DEF : default widths
//   nco_state_t : FSM encoding IDLE=0 .. OUT=4
package nco_pkg;

    localparam int PHASE_W_DEF = 24;
    localparam int ADDR_W_DEF  = 8;
    localparam int DATA_W_DEF  = 21;
    localparam int FRAC_W_DEF  = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        CAPT = 3'd2,
        MUL  = 3'd3,
        OUT  = 3'd4
    } nco_state_t;

endpackage

// File: rtl/nco_interp_mac.sv
// nco_interp_mac: registered linear interpolation y = a + floor(diff*frac / 2^FRAC_W).
//   clk, rst_n : clock, async active-low reset (y clears to 0)
//   ld         : load y this cycle
//   a          : base ROM word (signed, DATA_W)
//   diff       : b - a (signed, DATA_W+1)
//   frac       : unsigned interpolation fraction (FRAC_W)
//   y          : interpolated sample (DATA_W)
module nco_interp_mac #(
    parameter int DATA_W = 21,
    parameter int FRAC_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ld,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W:0]   diff,
    input  logic        [FRAC_W-1:0] frac,
    output logic        [DATA_W-1:0] y
);

    // Full product width: (DATA_W+1) signed times (FRAC_W+1) signed.
    localparam int PW = DATA_W + FRAC_W + 2;

    logic signed [PW-1:0] diff_ext;
    logic signed [PW-1:0] frac_ext;
    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] sum;
    logic [PW-DATA_W-1:0] unused_hi;

    assign diff_ext = PW'(diff);
    assign frac_ext = PW'($signed({1'b0, frac}));
    assign a_ext    = PW'(a);
    assign prod     = diff_ext * frac_ext;
    // Arithmetic shift floors; result stays between a and b so the
    // upper bits are pure sign extension and can be dropped.
    assign sum       = a_ext + (prod >>> FRAC_W);
    assign unused_hi = sum[PW-1:DATA_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  y <= '0;
        else if (ld) y <= sum[DATA_W-1:0];
    end

endmodule

// File: rtl/triangle_nco.sv
// triangle_nco: phase-accumulator NCO driving a dual-port registered triangle ROM,
// linearly interpolating between adjacent entries, with a valid/ready output.
//   clk, rst_n          : clock, async active-low reset
//   en, fcw, phase_sync : run enable, phase increment, phase reset request
//   lut_en*/addr*/dout* : ROM ports A (idx) and B (idx+1)
//   sample, sample_valid, sample_ready : output handshake
//   busy                : FSM not idle
// Build option: NCO_INTERP_EN enables interpolation (port B + MUL state);
// without it the sample is the raw port A word.
module triangle_nco
    import nco_pkg::*;
#(
    parameter int PHASE_W = PHASE_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int FRAC_W  = FRAC_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [PHASE_W-1:0] fcw,
    input  logic               phase_sync,
    output logic               lut_ena,
    output logic [ADDR_W-1:0]  lut_addra,
    input  logic [DATA_W-1:0]  lut_douta,
    output logic               lut_enb,
    output logic [ADDR_W-1:0]  lut_addrb,
    input  logic [DATA_W-1:0]  lut_doutb,
    output logic [DATA_W-1:0]  sample,
    output logic               sample_valid,
    input  logic               sample_ready,
    output logic               busy
);

    nco_state_t         state_q, state_d;
    logic [PHASE_W-1:0] phase_q;
    logic               sync_pending_q;
    logic [ADDR_W-1:0]  idx;
    logic               hs;

    assign idx = phase_q[PHASE_W-1 -: ADDR_W];
    assign hs  = (state_q == OUT) && sample_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (en) state_d = READ;
            READ: state_d = CAPT;
`ifdef NCO_INTERP_EN
            CAPT: state_d = MUL;
            MUL:  state_d = OUT;
`else
            CAPT: state_d = OUT;
`endif
            OUT:  if (sample_ready) state_d = en ? READ : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Phase only moves at the handshake (or a sync while idle), so it is
    // stable for the whole sample and fcw is effectively sampled there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q        <= '0;
            sync_pending_q <= 1'b0;
        end else if (state_q == IDLE) begin
            if (phase_sync) phase_q <= '0;
        end else if (hs) begin
            phase_q        <= (sync_pending_q || phase_sync) ? '0 : phase_q + fcw;
            sync_pending_q <= 1'b0;
        end else if (phase_sync) begin
            sync_pending_q <= 1'b1;
        end
    end

    assign lut_ena      = (state_q == READ);
    assign lut_addra    = (state_q == READ) ? idx : '0;
    assign sample_valid = (state_q == OUT);
    assign busy         = (state_q != IDLE);

`ifdef NCO_INTERP_EN
    logic signed [DATA_W-1:0] a_q;
    logic signed [DATA_W:0]   diff_q;
    logic        [FRAC_W-1:0] frac_q;

    assign lut_enb   = (state_q == READ);
    assign lut_addrb = (state_q == READ) ? idx + ADDR_W'(1) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            diff_q <= '0;
            frac_q <= '0;
        end else if (state_q == CAPT) begin
            a_q    <= lut_douta;
            diff_q <= {lut_doutb[DATA_W-1], lut_doutb} - {lut_douta[DATA_W-1], lut_douta};
            frac_q <= phase_q[PHASE_W-ADDR_W-1 -: FRAC_W];
        end
    end

    nco_interp_mac #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .ld    (state_q == MUL),
        .a     (a_q),
        .diff  (diff_q),
        .frac  (frac_q),
        .y     (sample)
    );
`else
    logic unused_doutb;

    assign lut_enb      = 1'b0;
    assign lut_addrb    = '0;
    assign unused_doutb = ^lut_doutb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 sample <= '0;
        else if (state_q == CAPT)   sample <= lut_douta;
    end
`endif

endmodule
